// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// The fetch-queue entry pairs a fetch PC with the instruction read from it.
package fetch_pkg;

    localparam int XLEN_DEF    = 32;
    localparam int ILEN_DEF    = 32;
    localparam int INSTR_BYTES = 4;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef struct packed {
        logic [XLEN_DEF-1:0] pc;
        logic [ILEN_DEF-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO of fetch entries with a single-cycle flush.
// DEPTH is a power of two, so the read and write pointers wrap without compare logic.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int  DEPTH   = 2,
    parameter type entry_t = fetch_entry_t,
    localparam int PW      = $clog2(DEPTH),
    localparam int CW      = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  entry_t        push_data,
    input  logic          pop,
    input  logic          flush,
    output entry_t        head,
    output logic [CW-1:0] count
);

    entry_t        mem_r [DEPTH];
    logic [PW-1:0] wr_ptr_r;
    logic [PW-1:0] rd_ptr_r;
    logic [CW-1:0] count_r;

    // Pointer and occupancy update; flush empties the queue in one cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else if (flush) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (push) begin
                wr_ptr_r <= wr_ptr_r + PW'(1);
            end
            if (pop) begin
                rd_ptr_r <= rd_ptr_r + PW'(1);
            end
            case ({push, pop})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Entry storage; stale slots are never visible because the head is masked when empty.
    always_ff @(posedge clk) begin
        if (push && !flush && !rst) begin
            mem_r[wr_ptr_r] <= push_data;
        end
    end

    assign head  = (count_r != '0) ? mem_r[rd_ptr_r] : '0;
    assign count = count_r;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC sequencing, one-cycle-latency memory reads, and a
// flushable fetch queue presented to decode with valid/ready backpressure.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter int              ILEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(DEFAULT_RESET_PC),
    parameter int              FQ_DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            fetch_en,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_en,
    output logic [XLEN-1:0] imem_addr,
    input  logic [ILEN-1:0] imem_rdata,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [ILEN-1:0] out_instr
);

    localparam int              CW         = $clog2(FQ_DEPTH + 1);
    localparam logic [CW:0]     DEPTH_L    = (CW + 1)'(FQ_DEPTH);
    localparam logic [XLEN-1:0] STEP       = XLEN'(INSTR_BYTES);
    localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(INSTR_BYTES - 1);

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [ILEN-1:0] instr;
    } entry_t;

    logic [XLEN-1:0] pc_r;
    logic            inflight_r;
    logic [XLEN-1:0] inflight_pc_r;

    logic            pop_s;
    logic            push_s;
    logic            issue_s;
    logic [CW:0]     occ_s;
    logic [CW-1:0]   fifo_count_s;
    entry_t          head_s;
    entry_t          push_data_s;

    // Issue rule: queue entries plus the outstanding read, less this cycle's pop, must leave room.
    always_comb begin
        pop_s       = (fifo_count_s != '0) & out_ready;
        occ_s       = {1'b0, fifo_count_s} + {{CW{1'b0}}, inflight_r} - {{CW{1'b0}}, pop_s};
        push_s      = inflight_r & ~redirect_valid;
        push_data_s = '{pc: inflight_pc_r, instr: imem_rdata};
        if (rst) begin
            issue_s = 1'b0;
        end else begin
            issue_s = fetch_en & ~redirect_valid & (occ_s < DEPTH_L);
        end
    end

    // PC and in-flight tracking; a redirect kills the outstanding read and retargets fetch.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_r          <= RESET_PC;
            inflight_r    <= 1'b0;
            inflight_pc_r <= '0;
        end else if (redirect_valid) begin
            pc_r          <= redirect_pc & ALIGN_MASK;
            inflight_r    <= 1'b0;
            inflight_pc_r <= inflight_pc_r;
        end else if (issue_s) begin
            pc_r          <= pc_r + STEP;
            inflight_r    <= 1'b1;
            inflight_pc_r <= pc_r;
        end else begin
            pc_r          <= pc_r;
            inflight_r    <= 1'b0;
            inflight_pc_r <= inflight_pc_r;
        end
    end

    fetch_fifo #(
        .DEPTH   (FQ_DEPTH),
        .entry_t (entry_t)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push_s),
        .push_data (push_data_s),
        .pop       (pop_s),
        .flush     (redirect_valid),
        .head      (head_s),
        .count     (fifo_count_s)
    );

    assign imem_en   = issue_s;
    assign imem_addr = pc_r;
    assign out_valid = (fifo_count_s != '0);
    assign out_pc    = head_s.pc;
    assign out_instr = head_s.instr;

endmodule
